dual_port_ram_bank: RTL and testbench
=====================================

# dual_port_ram_bank

Single-clock, true dual-port RAM bank with parametrised width and depth, per-byte write enables, selectable read-during-write behaviour, defined same-address collision resolution, and a sequenced memory clear. It succeeds the earlier fixed dual-port RAM as the general storage primitive behind buffers and register files, and replaces the parallel reset clear with a word-per-cycle clear sequencer.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane
- DEPTH, 16, number of words; must be at least 2
- ADDR_WIDTH, $clog2(DEPTH), address width
- RDW_MODE, 0, same-port read-during-write: 0 = old data, 1 = new merged data

Ports:
- clk_A  in  1  clock for both ports
- reset  in  1  asynchronous, active-high
- clear_req  in  1  one-cycle request to zero the whole memory
- busy  out  1  clear in progress; port accesses ignored
- collision  out  1  both ports wrote the same address; aligned with rvalid
- en_A, en_B  in  1  port access enable
- we_A, we_B  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables; all zero means read
- addr_A, addr_B  in  ADDR_WIDTH  word address
- wdata_A, wdata_B  in  DATA_WIDTH  write data
- rdata_A, rdata_B  out  DATA_WIDTH  read data
- rvalid_A, rvalid_B  out  1  one-cycle pulse; rdata updated for the accepted access

## Operation
- FSM states: CLEAR, READY. Reset forces CLEAR with clear counter at 0.
- CLEAR: writes zero to address counter, increments by 1 per cycle. After writing DEPTH-1, moves to READY next cycle. busy=1 throughout. en_A/en_B ignored; no rvalid.
- READY: busy=0. clear_req=1 moves to CLEAR at counter 0 and does not accept that cycle's port accesses. clear_req during CLEAR is ignored.
- An access is accepted when en_x=1 in READY. Every accepted access pulses rvalid_x.
- Read (we_x all zero): rdata_x = mem[addr_x].
- Write: only lanes with we_x[i]=1 update; other lanes keep their value.
- Same-port write return: RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns the merged post-write word.
- Cross-port: a read on one port at the address written by the other port in the same cycle returns the pre-write word, in both modes.
- Dual write, same address: port A wins on lanes enabled on both ports. Port B lanes not enabled on A are still written. collision pulses for any same-address dual write, even with disjoint lanes.
- Addresses at or above DEPTH (non-power-of-two DEPTH): writes are dropped, reads return 0, rvalid still pulses.
- Reset mid-clear or mid-access: the clear restarts from 0. Any in-flight read result is lost.
- Reset does not touch the array directly. The array is zeroed only by the sequencer.

## Timing
- Reset values: rdata_A/B=0, rvalid_A/B=0, collision=0, busy=1.
- busy stays high for exactly DEPTH cycles after the first clk_A edge following reset deassertion, and for DEPTH cycles after an accepted clear_req.
- Read latency is 1 cycle: access at edge N, then rdata/rvalid valid after edge N+1 (N+2 with output register).
- rdata holds its last value when rvalid=0.
- Back-to-back accesses are accepted every cycle on both ports.

## Configuration
- DUAL_PORT_RAM_BANK_OUT_REG_EN defined: adds one output register stage. rdata, rvalid and collision are delayed by one extra cycle (latency 2). The output stage resets to 0 and is flushed when clear starts.
- Not defined: latency 1, as above.

## Structure
- Package dual_port_ram_bank_pkg holds:
  - FSM state enum (ST_CLEAR, ST_READY)
  - RDW_OLD=0 and RDW_NEW=1 constants
  - byte-merge function (old word, new word, lane enables)
- Sub-module dual_port_ram_bank_clear_seq: owns the state register and clear counter, and outputs busy, clear address and clear write strobe.

## Test plan
Defaults apply (DATA_WIDTH=32, DEPTH=16).
- Reset release, then count cycles: busy high for exactly 16 cycles. A read on A at address 5 afterwards returns 0x00000000 with rvalid_A.
- Port A writes 0xDEADBEEF to address 3 with we=4'hF, then port B reads address 3: rdata_B=0xDEADBEEF one cycle after the read.
- Address 7 holds 0x11223344. Port A writes 0xAABBCCDD with we=4'b0101, then reads: 0x11BB33DD.
- Same cycle, both ports write address 9: A with 0xAAAAAAAA we=4'b0011, B with 0xBBBBBBBB we=4'b0110. Result 0x00BBAAAA and collision=1.
- Address 2 holds 0x1, and port A writes 0x2 to it with a same-port read. RDW_MODE=0 returns 0x1; RDW_MODE=1 returns 0x2. A port-B read of address 2 in the same cycle returns 0x1 in both modes.
- Assert clear_req, then assert reset at clear count 8: busy stays high for a full 16 cycles after reset release, and all words read 0.

Source files
------------

// File: rtl/dual_port_ram_bank_pkg.sv
// Shared types and helpers for dual_port_ram_bank: FSM state, read-during-write
// mode constants and the byte-lane merge used by both write ports.
package dual_port_ram_bank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word / most lanes the merge helper handles; callers zero-extend into it.
  localparam int MERGE_W     = 256;
  localparam int MERGE_LANES = 32;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]     old_word,
    input logic [MERGE_W-1:0]     new_word,
    input logic [MERGE_LANES-1:0] lane_en,
    input int unsigned            byte_w
  );
    logic [MERGE_W-1:0]     lane_mask;
    logic [MERGE_W-1:0]     bit_mask;
    logic [MERGE_LANES-1:0] en_sh;
    lane_mask = {MERGE_W{1'b1}} >> (MERGE_W - byte_w);
    bit_mask  = '0;
    for (int l = 0; l < MERGE_LANES; l++) begin
      en_sh = lane_en >> l;
      if (en_sh[0]) bit_mask = bit_mask | (lane_mask << (l * byte_w));
    end
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/dual_port_ram_bank_clear_seq.sv
// Clear sequencer: walks every address once writing zero, then idles in READY
// until the next clear request. Owns the bank's only FSM.
module dual_port_ram_bank_clear_seq
  import dual_port_ram_bank_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_A,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_A or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy       = (state == ST_CLEAR);
  assign clear_we   = busy;
  assign clear_addr = cnt;

endmodule

// File: rtl/dual_port_ram_bank.sv
// True dual-port RAM bank with byte enables, selectable same-port read-during-write
// and a sequenced clear. Define DUAL_PORT_RAM_BANK_OUT_REG_EN for a registered output stage.
module dual_port_ram_bank
  import dual_port_ram_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                             clk_A,
  input  logic                             reset,
  input  logic                             clear_req,
  output logic                             busy,
  output logic                             collision,
  input  logic                             en_A,
  input  logic                             en_B,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_A,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_B,
  input  logic [ADDR_WIDTH-1:0]            addr_A,
  input  logic [ADDR_WIDTH-1:0]            addr_B,
  input  logic [DATA_WIDTH-1:0]            wdata_A,
  input  logic [DATA_WIDTH-1:0]            wdata_B,
  output logic [DATA_WIDTH-1:0]            rdata_A,
  output logic [DATA_WIDTH-1:0]            rdata_B,
  output logic                             rvalid_A,
  output logic                             rvalid_B
);

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dual_port_ram_bank_clear_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk_A      (clk_A),
    .reset      (reset),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_we   (clr_we),
    .clear_addr (clr_addr)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rng_a, rng_b;
  logic                  acc_a, acc_b, wr_a, wr_b, col, same;
  logic [DATA_WIDTH-1:0] old_a, old_b, word_a, word_b, rd_a, rd_b;

  // Non-power-of-two depths leave a hole at the top of the address space.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
    assign rng_a = 1'b1;
    assign rng_b = 1'b1;
  end else begin : g_npow2
    assign rng_a = 32'(addr_A) < 32'(DEPTH);
    assign rng_b = 32'(addr_B) < 32'(DEPTH);
  end

  always_comb begin
    // A clear request in READY takes the cycle; port traffic is dropped.
    acc_a = en_A & ~busy & ~clear_req;
    acc_b = en_B & ~busy & ~clear_req;
    wr_a  = acc_a & rng_a & (|we_A);
    wr_b  = acc_b & rng_b & (|we_B);
    col   = acc_a & acc_b & (|we_A) & (|we_B) & (addr_A == addr_B);
    same  = wr_a & wr_b & (addr_A == addr_B);
    old_a = rng_a ? mem[addr_A] : '0;
    old_b = rng_b ? mem[addr_B] : '0;
    word_b = DATA_WIDTH'(byte_merge(MERGE_W'(old_b), MERGE_W'(wdata_B),
                                    MERGE_LANES'(we_B), BYTE_WIDTH));
    // On a shared address A merges over B's result, so A wins overlapping lanes.
    word_a = DATA_WIDTH'(byte_merge(MERGE_W'(same ? word_b : old_a), MERGE_W'(wdata_A),
                                    MERGE_LANES'(we_A), BYTE_WIDTH));
    rd_a = old_a;
    rd_b = old_b;
    if (RDW_MODE == RDW_NEW) begin
      if (wr_a) rd_a = word_a;
      if (wr_b) rd_b = same ? word_a : word_b;
    end
  end

  always_ff @(posedge clk_A) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr_b) mem[addr_B] <= word_b;
      if (wr_a) mem[addr_A] <= word_a;
    end
  end

  logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;
  logic                  rv_a_q, rv_b_q, col_q;

  always_ff @(posedge clk_A or posedge reset) begin
    if (reset) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      rv_a_q <= 1'b0;
      rv_b_q <= 1'b0;
      col_q  <= 1'b0;
    end else begin
      rv_a_q <= acc_a;
      rv_b_q <= acc_b;
      col_q  <= col;
      if (acc_a) rd_a_q <= rd_a;
      if (acc_b) rd_b_q <= rd_b;
    end
  end

`ifdef DUAL_PORT_RAM_BANK_OUT_REG_EN
  logic                  clr_start;
  logic [DATA_WIDTH-1:0] rd_a_q2, rd_b_q2;
  logic                  rv_a_q2, rv_b_q2, col_q2;

  assign clr_start = clear_req & ~busy;

  always_ff @(posedge clk_A or posedge reset) begin
    if (reset) begin
      rd_a_q2 <= '0;
      rd_b_q2 <= '0;
      rv_a_q2 <= 1'b0;
      rv_b_q2 <= 1'b0;
      col_q2  <= 1'b0;
    end else if (clr_start) begin
      rd_a_q2 <= '0;
      rd_b_q2 <= '0;
      rv_a_q2 <= 1'b0;
      rv_b_q2 <= 1'b0;
      col_q2  <= 1'b0;
    end else begin
      rv_a_q2 <= rv_a_q;
      rv_b_q2 <= rv_b_q;
      col_q2  <= col_q;
      if (rv_a_q) rd_a_q2 <= rd_a_q;
      if (rv_b_q) rd_b_q2 <= rd_b_q;
    end
  end

  assign rdata_A   = rd_a_q2;
  assign rdata_B   = rd_b_q2;
  assign rvalid_A  = rv_a_q2;
  assign rvalid_B  = rv_b_q2;
  assign collision = col_q2;
`else
  assign rdata_A   = rd_a_q;
  assign rdata_B   = rd_b_q;
  assign rvalid_A  = rv_a_q;
  assign rvalid_B  = rv_b_q;
  assign collision = col_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_bank.sv
// Directed bench for dual_port_ram_bank: one instance per read-during-write mode,
// shared stimulus, hand-computed expectations.
module tb_dual_port_ram_bank;

`ifdef DUAL_PORT_RAM_BANK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_A = 1'b0;
  logic        reset = 1'b1;
  logic        clear_req = 1'b0;
  logic        en_A = 1'b0, en_B = 1'b0;
  logic [3:0]  we_A = '0, we_B = '0;
  logic [3:0]  addr_A = '0, addr_B = '0;
  logic [31:0] wdata_A = '0, wdata_B = '0;

  logic [31:0] r_a0, r_b0, r_a1, r_b1;
  logic        v_a0, v_b0, v_a1, v_b1, col0, col1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk_A = ~clk_A;

  dual_port_ram_bank #(.RDW_MODE(0)) dut0 (
    .clk_A(clk_A), .reset(reset), .clear_req(clear_req), .busy(busy0), .collision(col0),
    .en_A(en_A), .en_B(en_B), .we_A(we_A), .we_B(we_B), .addr_A(addr_A), .addr_B(addr_B),
    .wdata_A(wdata_A), .wdata_B(wdata_B), .rdata_A(r_a0), .rdata_B(r_b0),
    .rvalid_A(v_a0), .rvalid_B(v_b0)
  );

  dual_port_ram_bank #(.RDW_MODE(1)) dut1 (
    .clk_A(clk_A), .reset(reset), .clear_req(clear_req), .busy(busy1), .collision(col1),
    .en_A(en_A), .en_B(en_B), .we_A(we_A), .we_B(we_B), .addr_A(addr_A), .addr_B(addr_B),
    .wdata_A(wdata_A), .wdata_B(wdata_B), .rdata_A(r_a1), .rdata_B(r_b1),
    .rvalid_A(v_a1), .rvalid_B(v_b1)
  );

  task automatic step();
    @(negedge clk_A);
  endtask

  task automatic idle();
    en_A = 1'b0; en_B = 1'b0; we_A = '0; we_B = '0; clear_req = 1'b0;
  endtask

  task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                       input logic [31:0] da, input logic eb, input logic [3:0] wb,
                       input logic [3:0] ab, input logic [31:0] db);
    en_A = ea; we_A = wa; addr_A = aa; wdata_A = da;
    en_B = eb; we_B = wb; addr_B = ab; wdata_B = db;
  endtask

  // One-cycle access, then wait until its result is on the outputs.
  task automatic access(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                        input logic [31:0] da, input logic eb, input logic [3:0] wb,
                        input logic [3:0] ab, input logic [31:0] db);
    drive(ea, wa, aa, da, eb, wb, ab, db);
    step();
    idle();
    repeat (LAT - 1) step();
  endtask

  // Count cycles with busy high, hammering a write to address 13 that must be ignored.
  task automatic count_busy(output int n, output logic saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while ((busy0 || busy1) && n < 100) begin
      drive(1'b1, 4'hF, 4'd13, 32'hFFFF_FFFF, 1'b0, 4'h0, 4'd0, 32'h0);
      step();
      n++;
      if (v_a0 || v_a1) saw_rv = 1'b1;
    end
    idle();
  endtask

  task automatic test_reset();
    int n;
    logic rv;
    reset = 1'b1;
    idle();
    repeat (2) step();
    checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b/%b expected 1", busy0, busy1); end
    checks++; if (r_a0 !== 32'h0 || r_b0 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", r_a0, r_b0); end
    checks++; if (v_a0 !== 1'b0 || v_b0 !== 1'b0 || col0 !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b%b expected 000", v_a0, v_b0, col0); end
    reset = 1'b0;
    count_busy(n, rv);
    checks++; if (n !== 16) begin errors++; $display("FAIL busy_cycles: got %0d expected 16", n); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL busy_ignores_access: got %b expected 0", rv); end
    access(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    checks++; if (r_a0 !== 32'h0 || v_a0 !== 1'b1) begin errors++; $display("FAIL read_after_clear: got %h v=%b expected 00000000 v=1", r_a0, v_a0); end
  endtask

  task automatic test_write_read();
    access(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'd0, 32'h0);
    checks++; if (v_a0 !== 1'b1 || r_a0 !== 32'h0) begin errors++; $display("FAIL write_old: got %h v=%b expected 00000000 v=1", r_a0, v_a0); end
    checks++; if (r_a1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_new: got %h expected deadbeef", r_a1); end
    access(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    checks++; if (r_b0 !== 32'hDEAD_BEEF || r_b1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_b: got %h/%h expected deadbeef", r_b0, r_b1); end
    checks++; if (v_b0 !== 1'b1 || v_a0 !== 1'b0) begin errors++; $display("FAIL read_b_valid: got b=%b a=%b expected b=1 a=0", v_b0, v_a0); end
  endtask

  task automatic test_byte_lanes();
    access(1'b1, 4'hF, 4'd7, 32'h1122_3344, 1'b0, 4'h0, 4'd0, 32'h0);
    access(1'b1, 4'b0101, 4'd7, 32'hAABB_CCDD, 1'b0, 4'h0, 4'd0, 32'h0);
    checks++; if (r_a0 !== 32'h1122_3344 || r_a1 !== 32'h11BB_33DD) begin errors++; $display("FAIL lane_write_return: got %h/%h expected 11223344/11bb33dd", r_a0, r_a1); end
    access(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    checks++; if (r_a0 !== 32'h11BB_33DD) begin errors++; $display("FAIL lane_merge: got %h expected 11bb33dd", r_a0); end
  endtask

  task automatic test_collision();
    access(1'b1, 4'b0011, 4'd9, 32'hAAAA_AAAA, 1'b1, 4'b0110, 4'd9, 32'hBBBB_BBBB);
    checks++; if (col0 !== 1'b1 || col1 !== 1'b1) begin errors++; $display("FAIL collision_flag: got %b/%b expected 1", col0, col1); end
    checks++; if (r_a1 !== 32'h00BB_AAAA) begin errors++; $display("FAIL collision_new_a: got %h expected 00bbaaaa", r_a1); end
    access(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
    checks++; if (r_a0 !== 32'h00BB_AAAA || r_b0 !== 32'h00BB_AAAA) begin errors++; $display("FAIL collision_data: got %h/%h expected 00bbaaaa", r_a0, r_b0); end
    checks++; if (col0 !== 1'b0) begin errors++; $display("FAIL collision_clear: got %b expected 0", col0); end
  endtask

  task automatic test_rdw();
    access(1'b1, 4'hF, 4'd2, 32'h1, 1'b0, 4'h0, 4'd0, 32'h0);
    access(1'b1, 4'hF, 4'd2, 32'h2, 1'b1, 4'h0, 4'd2, 32'h0);
    checks++; if (r_a0 !== 32'h1) begin errors++; $display("FAIL rdw_old: got %h expected 00000001", r_a0); end
    checks++; if (r_a1 !== 32'h2) begin errors++; $display("FAIL rdw_new: got %h expected 00000002", r_a1); end
    checks++; if (r_b0 !== 32'h1 || r_b1 !== 32'h1) begin errors++; $display("FAIL rdw_cross: got %h/%h expected 00000001", r_b0, r_b1); end
    checks++; if (col0 !== 1'b0) begin errors++; $display("FAIL rdw_no_collision: got %b expected 0", col0); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'hF, 4'd10, 32'h0000_A0A0, 1'b1, 4'hF, 4'd11, 32'h0000_B1B1);
    step();
    drive(1'b1, 4'h0, 4'd11, 32'h0, 1'b1, 4'h0, 4'd10, 32'h0);
    step();
    idle();
    repeat (LAT - 1) step();
    checks++; if (r_a0 !== 32'h0000_B1B1 || r_b0 !== 32'h0000_A0A0) begin errors++; $display("FAIL b2b_data: got %h/%h expected 0000b1b1/0000a0a0", r_a0, r_b0); end
    checks++; if (v_a0 !== 1'b1 || v_b0 !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b/%b expected 1/1", v_a0, v_b0); end
    step();
    checks++; if (v_a0 !== 1'b0 || r_a0 !== 32'h0000_B1B1) begin errors++; $display("FAIL rdata_hold: got %h v=%b expected 0000b1b1 v=0", r_a0, v_a0); end
  endtask

  task automatic test_clear_reset();
    int n;
    logic rv;
    logic ok;
    access(1'b1, 4'hF, 4'd12, 32'h1212_1212, 1'b1, 4'hF, 4'd15, 32'h1515_1515);
    drive(1'b1, 4'hF, 4'd14, 32'h5, 1'b0, 4'h0, 4'd0, 32'h0);
    clear_req = 1'b1;
    step();
    idle();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL clear_start_busy: got %b expected 1", busy0); end
    checks++; if (v_a0 !== 1'b0) begin errors++; $display("FAIL clear_drops_access: got %b expected 0", v_a0); end
    repeat (8) step();
    reset = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b1 || v_a0 !== 1'b0 || r_a0 !== 32'h0) begin errors++; $display("FAIL midclear_reset: got busy=%b v=%b d=%h expected 1 0 0", busy0, v_a0, r_a0); end
    repeat (2) step();
    reset = 1'b0;
    count_busy(n, rv);
    checks++; if (n !== 16) begin errors++; $display("FAIL restart_busy_cycles: got %0d expected 16", n); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL restart_ignores_access: got %b expected 0", rv); end
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
      ok = (r_a0 === 32'h0) && (r_b0 === 32'h0) && (r_a1 === 32'h0) && (r_b1 === 32'h0)
           && (v_a0 === 1'b1) && (v_b1 === 1'b1);
      checks++; if (!ok) begin errors++; $display("FAIL cleared_word_%0d: got %h/%h/%h/%h expected 0", i, r_a0, r_b0, r_a1, r_b1); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_collision();
    test_rdw();
    test_back_to_back();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
